// File: rtl/pipelined_mux_tree_pkg.sv
// Shared constants and sizing helpers for the pipelined radix-4 mux tree.
package mux_tree_pkg;

  localparam int RADIX              = 4;
  localparam int SEL_BITS_PER_LEVEL = 2;

  // Number of selectable input words for a tree of the given depth.
  function automatic int n_inputs(input int levels);
    return RADIX ** levels;
  endfunction

  // Width of a full input index for a tree of the given depth.
  function automatic int sel_width(input int levels);
    return SEL_BITS_PER_LEVEL * levels;
  endfunction

  // Index of the first node of tree level `level` in a flat node array,
  // where level 0 (the leaves side) comes first and the root comes last.
  // level_base(levels, levels) is the total number of nodes.
  function automatic int level_base(input int levels, input int level);
    int base;
    base = 0;
    for (int m = 0; m < level; m++) begin
      base += n_inputs(levels - 1 - m);
    end
    return base;
  endfunction

endpackage

// File: rtl/pipelined_mux_tree_if.sv
// Bus between a wide data source (master) and the mux tree (slave).
interface pipelined_mux_tree_if
  import mux_tree_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int LEVELS = 2
);

  localparam int N  = n_inputs(LEVELS);
  localparam int SW = sel_width(LEVELS);

  logic [N*WIDTH-1:0] data;
  logic [SW-1:0]      select;
  logic               in_valid;
  logic               scan_en;
  logic [WIDTH-1:0]   out;
  logic               out_valid;
  logic [SW-1:0]      out_sel;
  logic               scan_wrap;

  modport master (
    output data, select, in_valid, scan_en,
    input  out, out_valid, out_sel, scan_wrap
  );

  modport slave (
    input  data, select, in_valid, scan_en,
    output out, out_valid, out_sel, scan_wrap
  );

endinterface

// File: rtl/pipelined_mux_tree_mux4_stage.sv
// One registered 4:1 mux node of the tree; holds its value when not enabled.
module mux4_stage
  import mux_tree_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              d0,
  input  logic [WIDTH-1:0]              d1,
  input  logic [WIDTH-1:0]              d2,
  input  logic [WIDTH-1:0]              d3,
  input  logic [SEL_BITS_PER_LEVEL-1:0] sel,
  input  logic                          en,
  output logic [WIDTH-1:0]              q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Pick one of the four words when a valid word passes through this level.
  always_comb begin
    q_d = q_q;
    if (en) begin
      case (sel)
        2'd0:    q_d = d0;
        2'd1:    q_d = d1;
        2'd2:    q_d = d2;
        default: q_d = d3;
      endcase
    end
  end

  // Node register, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipelined_mux_tree.sv
// Pipelined radix-4 mux tree: one register level per tree level, with the
// valid bit, the full select and the scan-wrap flag shifting alongside the
// data so every output word is reported with the index that produced it.
module pipelined_mux_tree
  import mux_tree_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int LEVELS = 2
) (
  input logic                 clk,
  input logic                 rst,
  pipelined_mux_tree_if.slave bus
);

  localparam int N     = n_inputs(LEVELS);
  localparam int SW    = sel_width(LEVELS);
  localparam int NODES = level_base(LEVELS, LEVELS);
  localparam int ROOT  = NODES - 1;
  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  logic [SW-1:0]             scan_cnt_q;
  logic [SW-1:0]             scan_cnt_d;
  logic [SW-1:0]             eff_sel;
  logic [LEVELS-1:0]         valid_q;
  logic [LEVELS-1:0]         valid_d;
  logic [LEVELS-1:0]         wrap_q;
  logic [LEVELS-1:0]         wrap_d;
  logic [LEVELS-1:0][SW-1:0] sel_q;
  logic [LEVELS-1:0][SW-1:0] sel_d;
  logic [WIDTH-1:0]          node [NODES];

  // Effective select and scan counter; the counter is exactly SW bits wide,
  // so N-1 rolls over to 0 without an explicit compare.
  always_comb begin
    eff_sel    = bus.scan_en ? scan_cnt_q : bus.select;
    scan_cnt_d = scan_cnt_q;
    if (bus.scan_en && bus.in_valid) begin
      scan_cnt_d = scan_cnt_q + SW'(1);
    end
  end

  // Sideband shift pipeline: launch at stage 0, then advance unconditionally.
  always_comb begin
    valid_d[0] = bus.in_valid;
    sel_d[0]   = eff_sel;
    wrap_d[0]  = bus.in_valid && bus.scan_en && (scan_cnt_q == LAST_IDX);
    for (int k = 1; k < LEVELS; k++) begin
      valid_d[k] = valid_q[k-1];
      sel_d[k]   = sel_q[k-1];
      wrap_d[k]  = wrap_q[k-1];
    end
  end

  // Sideband and scan counter registers; reset flushes every in-flight word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      valid_q    <= '0;
      sel_q      <= '0;
      wrap_q     <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      wrap_q     <= wrap_d;
    end
  end

  // Tree levels stored flat in node[]: level 0 first, root last. Level 0
  // reads the input words directly, so each output is a snapshot of `data`
  // from its launch cycle; deeper levels only read the previous level.
  for (genvar k = 0; k < LEVELS; k++) begin : g_level
    localparam int CNT  = n_inputs(LEVELS - 1 - k);
    localparam int BASE = level_base(LEVELS, k);
    localparam int PREV = (k == 0) ? 0 : level_base(LEVELS, k - 1);

    for (genvar j = 0; j < CNT; j++) begin : g_node
      logic [WIDTH-1:0]              w [RADIX];
      logic [SEL_BITS_PER_LEVEL-1:0] s;
      logic                          en;

      if (k == 0) begin : g_leaf
        for (genvar m = 0; m < RADIX; m++) begin : g_in
          assign w[m] = bus.data[(RADIX*j + m)*WIDTH +: WIDTH];
        end
        assign s  = eff_sel[SEL_BITS_PER_LEVEL-1:0];
        assign en = bus.in_valid;
      end else begin : g_inner
        for (genvar m = 0; m < RADIX; m++) begin : g_in
          assign w[m] = node[PREV + RADIX*j + m];
        end
        assign s  = sel_q[k-1][SEL_BITS_PER_LEVEL*k +: SEL_BITS_PER_LEVEL];
        assign en = valid_q[k-1];
      end

      mux4_stage #(.WIDTH(WIDTH)) u_mux (
        .clk (clk),
        .rst (rst),
        .d0  (w[0]),
        .d1  (w[1]),
        .d2  (w[2]),
        .d3  (w[3]),
        .sel (s),
        .en  (en),
        .q   (node[BASE + j])
      );
    end
  end

  assign bus.out       = node[ROOT];
  assign bus.out_valid = valid_q[LEVELS-1];
  assign bus.out_sel   = sel_q[LEVELS-1];
  assign bus.scan_wrap = wrap_q[LEVELS-1];

endmodule

// File: tb/tb_pipelined_mux_tree.sv
// Bench for pipelined_mux_tree: four instances (default, WIDTH=8, and
// WIDTH=4 with LEVELS=1 and 3) checked against a per-launch expectation
// queue computed from the selection rules.
module tb_pipelined_mux_tree;
  import mux_tree_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit         v;
    logic [7:0] word;
    logic [5:0] sel;
    bit         wrap;
  } exp_t;

  exp_t q0[$];
  exp_t q8[$];
  exp_t q1[$];
  exp_t q3[$];
  int   cnt0 = 0;
  int   cnt1 = 0;
  int   cnt3 = 0;

  pipelined_mux_tree_if #(.WIDTH(1), .LEVELS(2)) bus0 ();
  pipelined_mux_tree_if #(.WIDTH(8), .LEVELS(2)) bus8 ();
  pipelined_mux_tree_if #(.WIDTH(4), .LEVELS(1)) bus1 ();
  pipelined_mux_tree_if #(.WIDTH(4), .LEVELS(3)) bus3 ();

  pipelined_mux_tree #(.WIDTH(1), .LEVELS(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  pipelined_mux_tree #(.WIDTH(8), .LEVELS(2)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  pipelined_mux_tree #(.WIDTH(4), .LEVELS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pipelined_mux_tree #(.WIDTH(4), .LEVELS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

  // Drive one cycle on the default instance and queue what it must produce.
  task automatic u0_drive(input bit v, input bit sc, input logic [3:0] sel, input logic [15:0] d);
    exp_t e;
    int   es;
    bus0.in_valid = v;
    bus0.scan_en  = sc;
    bus0.select   = sel;
    bus0.data     = d;
    es     = sc ? cnt0 : int'(sel);
    e.v    = v;
    e.word = 8'(d[es]);
    e.sel  = 6'(es);
    e.wrap = v && sc && (es == 15);
    if (v && sc) cnt0 = (cnt0 + 1) % 16;
    q0.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid0: got %0b want 0", bus0.out_valid); end
    checks++; if (bus0.out !== 1'b0) begin errors++; $display("FAIL reset out0: got %0h want 0", bus0.out); end
    checks++; if (bus0.out_sel !== 4'd0) begin errors++; $display("FAIL reset out_sel0: got %0d want 0", bus0.out_sel); end
    checks++; if (bus0.scan_wrap !== 1'b0) begin errors++; $display("FAIL reset scan_wrap0: got %0b want 0", bus0.scan_wrap); end
    checks++; if (bus8.out_valid !== 1'b0 || bus8.out !== 8'h00) begin errors++; $display("FAIL reset w8: got valid=%0b out=%0h want 0/0", bus8.out_valid, bus8.out); end
    checks++; if (bus1.out_valid !== 1'b0 || bus1.out_sel !== 2'd0) begin errors++; $display("FAIL reset l1: got valid=%0b sel=%0d want 0/0", bus1.out_valid, bus1.out_sel); end
    checks++; if (bus3.out_valid !== 1'b0 || bus3.out_sel !== 6'd0) begin errors++; $display("FAIL reset l3: got valid=%0b sel=%0d want 0/0", bus3.out_valid, bus3.out_sel); end
    rst = 1'b0;
  endtask

  task automatic test_fixed_select();
    exp_t e;
    int   pulses;
    pulses = 0;
    q0.delete();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (bus0.out_valid === 1'b1) pulses++;
      if (q0.size() == 2) begin
        e = q0.pop_front();
        checks++; if (bus0.out_valid !== e.v) begin errors++; $display("FAIL fixed valid i=%0d: got %0b want %0b", i, bus0.out_valid, e.v); end
        if (e.v) begin
          checks++; if (bus0.out !== e.word[0]) begin errors++; $display("FAIL fixed out: got %0b want %0b", bus0.out, e.word[0]); end
          checks++; if (bus0.out_sel !== e.sel[3:0]) begin errors++; $display("FAIL fixed out_sel: got %0d want %0d", bus0.out_sel, e.sel); end
        end
      end
      u0_drive(i == 0, 1'b0, 4'd5, 16'hAAAA);
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL fixed pulse count: got %0d want 1", pulses); end
  endtask

  task automatic test_streaming();
    exp_t e;
    exp_t n;
    int   nvalid;
    nvalid = 0;
    q8.delete();
    for (int w = 0; w < 16; w++) bus8.data[w*8 +: 8] = 8'hA0 + 8'(w);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (q8.size() == 2) begin
        e = q8.pop_front();
        checks++; if (bus8.out_valid !== e.v) begin errors++; $display("FAIL stream valid i=%0d: got %0b want %0b", i, bus8.out_valid, e.v); end
        if (e.v) begin
          nvalid++;
          checks++; if (bus8.out !== e.word) begin errors++; $display("FAIL stream out: got %0h want %0h", bus8.out, e.word); end
          checks++; if (bus8.out_sel !== e.sel[3:0]) begin errors++; $display("FAIL stream out_sel: got %0d want %0d", bus8.out_sel, e.sel); end
        end
      end
      bus8.in_valid = (i < 16);
      bus8.scan_en  = 1'b0;
      bus8.select   = 4'(i);
      n.v    = (i < 16);
      n.word = 8'hA0 + 8'(i);
      n.sel  = 6'(i);
      n.wrap = 1'b0;
      q8.push_back(n);
    end
    bus8.in_valid = 1'b0;
    checks++; if (nvalid != 16) begin errors++; $display("FAIL stream count: got %0d want 16", nvalid); end
  endtask

  task automatic test_scan();
    exp_t e;
    int   wraps;
    wraps = 0;
    q0.delete();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.scan_wrap === 1'b1) wraps++;
      if (q0.size() == 2) begin
        e = q0.pop_front();
        checks++; if (bus0.out_valid !== e.v) begin errors++; $display("FAIL scan valid i=%0d: got %0b want %0b", i, bus0.out_valid, e.v); end
        checks++; if (bus0.scan_wrap !== e.wrap) begin errors++; $display("FAIL scan wrap i=%0d: got %0b want %0b", i, bus0.scan_wrap, e.wrap); end
        if (e.v) begin
          checks++; if (bus0.out_sel !== e.sel[3:0]) begin errors++; $display("FAIL scan out_sel i=%0d: got %0d want %0d", i, bus0.out_sel, e.sel); end
          checks++; if (bus0.out !== e.word[0]) begin errors++; $display("FAIL scan out i=%0d: got %0b want %0b", i, bus0.out, e.word[0]); end
        end
      end
      u0_drive(i < 18, 1'b1, 4'($urandom()), 16'($urandom()));
    end
    checks++; if (wraps != 1) begin errors++; $display("FAIL scan wrap count: got %0d want 1", wraps); end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    q0.delete();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (q0.size() == 2) begin
        e = q0.pop_front();
        checks++; if (bus0.out_valid !== e.v) begin errors++; $display("FAIL rstmid valid i=%0d: got %0b want %0b", i, bus0.out_valid, e.v); end
        checks++; if (bus0.scan_wrap !== e.wrap) begin errors++; $display("FAIL rstmid wrap i=%0d: got %0b want %0b", i, bus0.scan_wrap, e.wrap); end
        if (e.v) begin
          checks++; if (bus0.out_sel !== e.sel[3:0]) begin errors++; $display("FAIL rstmid out_sel i=%0d: got %0d want %0d", i, bus0.out_sel, e.sel); end
        end
      end
      if (i < 15) u0_drive(1'b1, 1'b1, 4'd0, 16'($urandom()));
    end
    bus0.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL async flush valid: got %0b want 0", bus0.out_valid); end
    checks++; if (bus0.out_sel !== 4'd0) begin errors++; $display("FAIL async flush out_sel: got %0d want 0", bus0.out_sel); end
    checks++; if (bus0.scan_wrap !== 1'b0) begin errors++; $display("FAIL async flush wrap: got %0b want 0", bus0.scan_wrap); end
    @(negedge clk);
    rst  = 1'b0;
    cnt0 = 0;
    cnt1 = 0;
    cnt3 = 0;
    q0.delete();
    @(negedge clk);
    checks++; if (bus0.out_valid !== 1'b0) begin errors++; $display("FAIL post-reset valid: got %0b want 0", bus0.out_valid); end
  endtask

  task automatic test_scan_pause();
    exp_t e;
    int   seen[$];
    int   want[12];
    want = '{0, 1, 2, 3, 4, 9, 9, 9, 5, 6, 7, 8};
    q0.delete();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (q0.size() == 2) begin
        e = q0.pop_front();
        checks++; if (bus0.out_valid !== e.v) begin errors++; $display("FAIL pause valid i=%0d: got %0b want %0b", i, bus0.out_valid, e.v); end
        if (bus0.out_valid === 1'b1) seen.push_back(int'(bus0.out_sel));
        if (e.v) begin
          checks++; if (bus0.out !== e.word[0]) begin errors++; $display("FAIL pause out i=%0d: got %0b want %0b", i, bus0.out, e.word[0]); end
          checks++; if (bus0.scan_wrap !== 1'b0) begin errors++; $display("FAIL pause wrap i=%0d: got %0b want 0", i, bus0.scan_wrap); end
        end
      end
      if (i < 5 || (i >= 8 && i < 12)) u0_drive(1'b1, 1'b1, 4'd0, 16'($urandom()));
      else if (i < 8)                  u0_drive(1'b1, 1'b0, 4'd9, 16'($urandom()));
      else                             u0_drive(1'b0, 1'b0, 4'd0, 16'($urandom()));
    end
    checks++; if (seen.size() != 12) begin errors++; $display("FAIL pause seq length: got %0d want 12", seen.size()); end
    for (int k = 0; k < 12 && k < seen.size(); k++) begin
      checks++; if (seen[k] != want[k]) begin errors++; $display("FAIL pause seq[%0d]: got %0d want %0d", k, seen[k], want[k]); end
    end
  endtask

  task automatic test_random_l1();
    exp_t e;
    exp_t n;
    logic [15:0] d;
    logic [1:0]  sel;
    bit          v;
    bit          sc;
    int          es;
    q1.delete();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q1.size() == 1) begin
        e = q1.pop_front();
        checks++; if (bus1.out_valid !== e.v) begin errors++; $display("FAIL l1 valid i=%0d: got %0b want %0b", i, bus1.out_valid, e.v); end
        checks++; if (bus1.scan_wrap !== e.wrap) begin errors++; $display("FAIL l1 wrap i=%0d: got %0b want %0b", i, bus1.scan_wrap, e.wrap); end
        if (e.v) begin
          checks++; if (bus1.out !== e.word[3:0]) begin errors++; $display("FAIL l1 out i=%0d: got %0h want %0h", i, bus1.out, e.word[3:0]); end
          checks++; if (bus1.out_sel !== e.sel[1:0]) begin errors++; $display("FAIL l1 out_sel i=%0d: got %0d want %0d", i, bus1.out_sel, e.sel); end
        end
      end
      d   = 16'($urandom());
      sel = 2'($urandom());
      v   = ($urandom_range(0, 3) != 0);
      sc  = ($urandom_range(0, 2) == 0);
      bus1.data = d; bus1.select = sel; bus1.in_valid = v; bus1.scan_en = sc;
      es     = sc ? cnt1 : int'(sel);
      n.v    = v;
      n.word = 8'(d[es*4 +: 4]);
      n.sel  = 6'(es);
      n.wrap = v && sc && (es == 3);
      if (v && sc) cnt1 = (cnt1 + 1) % 4;
      q1.push_back(n);
    end
    bus1.in_valid = 1'b0;
  endtask

  task automatic test_random_l3();
    exp_t e;
    exp_t n;
    logic [255:0] d;
    logic [5:0]   sel;
    bit           v;
    bit           sc;
    int           es;
    q3.delete();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q3.size() == 3) begin
        e = q3.pop_front();
        checks++; if (bus3.out_valid !== e.v) begin errors++; $display("FAIL l3 valid i=%0d: got %0b want %0b", i, bus3.out_valid, e.v); end
        checks++; if (bus3.scan_wrap !== e.wrap) begin errors++; $display("FAIL l3 wrap i=%0d: got %0b want %0b", i, bus3.scan_wrap, e.wrap); end
        if (e.v) begin
          checks++; if (bus3.out !== e.word[3:0]) begin errors++; $display("FAIL l3 out i=%0d: got %0h want %0h", i, bus3.out, e.word[3:0]); end
          checks++; if (bus3.out_sel !== e.sel) begin errors++; $display("FAIL l3 out_sel i=%0d: got %0d want %0d", i, bus3.out_sel, e.sel); end
        end
      end
      for (int c = 0; c < 8; c++) d[c*32 +: 32] = $urandom();
      sel = 6'($urandom());
      v   = ($urandom_range(0, 3) != 0);
      sc  = ($urandom_range(0, 1) == 0);
      bus3.data = d; bus3.select = sel; bus3.in_valid = v; bus3.scan_en = sc;
      es     = sc ? cnt3 : int'(sel);
      n.v    = v;
      n.word = 8'(d[es*4 +: 4]);
      n.sel  = 6'(es);
      n.wrap = v && sc && (es == 63);
      if (v && sc) cnt3 = (cnt3 + 1) % 64;
      q3.push_back(n);
    end
    bus3.in_valid = 1'b0;
  endtask

  initial begin
    bus0.data = '0; bus0.select = '0; bus0.in_valid = 1'b0; bus0.scan_en = 1'b0;
    bus8.data = '0; bus8.select = '0; bus8.in_valid = 1'b0; bus8.scan_en = 1'b0;
    bus1.data = '0; bus1.select = '0; bus1.in_valid = 1'b0; bus1.scan_en = 1'b0;
    bus3.data = '0; bus3.select = '0; bus3.in_valid = 1'b0; bus3.scan_en = 1'b0;
    test_reset();
    test_fixed_select();
    test_streaming();
    test_scan();
    test_reset_mid();
    test_scan_pause();
    test_random_l1();
    test_random_l3();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pipelined_mux_tree.md
# pipelined_mux_tree

Parametrised, pipelined radix-4 multiplexer tree selecting one of `4**LEVELS` input words of `WIDTH` bits. It generalises the fixed 16:1, 1-bit combinational mux tree:
- one register stage per tree level, with a valid bit travelling alongside the data;
- the select that produced each output is reported with it;
- an auto-scan mode steps through all inputs in order.

It sits between wide data sources and a single serial consumer, such as a test readout or status scanner.

## Interface
Parameters:
- `WIDTH`, 1: bits per input word.
- `LEVELS`, 2: number of radix-4 tree levels, legal range 1–4. Number of inputs N = 4**LEVELS (default 16).

Ports:
- `clk`  in  1  single clock; rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `data`  in  N*WIDTH  input words; word i = `data[i*WIDTH +: WIDTH]`.
- `select`  in  2*LEVELS  input index used when `scan_en`=0.
- `in_valid`  in  1  sample `data` and the effective select this cycle.
- `scan_en`  in  1  1 = use the internal scan counter instead of `select`.
- `out`  out  WIDTH  selected word.
- `out_valid`  out  1  `out`/`out_sel` are valid this cycle.
- `out_sel`  out  2*LEVELS  index that produced `out`.
- `scan_wrap`  out  1  high together with the output for index N-1 when that index came from the scan counter.

## Operation
- Effective select is `eff_sel = scan_en ? scan_cnt : select`.
- Stage 0 (level 0) is launched by `in_valid`:
  - 4**(LEVELS-1) registered 4:1 muxes capture `data` using `eff_sel[1:0]`;
  - `eff_sel[2*LEVELS-1:2]` is registered with the data;
  - the full `eff_sel` is also carried for `out_sel`, plus the `scan_wrap` flag.
- Stage k (k ≥ 1) muxes stage k-1 results 4:1 using the carried bits `[2k+1:2k]`.
  - Stages always advance; no stall or backpressure.
  - The valid bit, carried select and wrap flag shift with the data.
- Bubbles: an `in_valid`=0 cycle inserts a bubble (valid=0).
  - Data registers may hold any value during a bubble.
  - `out`/`out_sel` are don't-care while `out_valid`=0; the bench must not check them then.
- Scan counter `scan_cnt` (2*LEVELS bits):
  - increments by 1 on each cycle with `in_valid`=1 and `scan_en`=1;
  - wraps from N-1 to 0;
  - holds otherwise, including while `scan_en`=0, so scanning resumes where it left off.
- Wrap flag: launched as 1 exactly when `scan_en`=1, `in_valid`=1 and `scan_cnt`=N-1.
- Selection is combinational only within a stage. Each input word is read only at stage 0, so one output word is a consistent snapshot of `data` from its launch cycle.

## Timing
- Latency is LEVELS cycles. Inputs sampled at edge t appear on `out` after edge t+LEVELS-1, i.e. registered at the LEVELS-th edge counting the launch edge.
  - LEVELS=2: launch at edge 0, output valid after edge 1.
- Throughput is one word per cycle; back-to-back `in_valid` yields back-to-back `out_valid`.
- Reset values: `out`=0, `out_valid`=0, `out_sel`=0, `scan_wrap`=0, `scan_cnt`=0, and all internal stage registers 0.
- Reset mid-operation flushes every in-flight valid immediately (asynchronous). The first post-reset launch occurs at the first rising edge after `rst` falls.
- Toggling `scan_en` mid-stream:
  - takes effect on the same cycle's launch;
  - in-flight words keep their own carried select;
  - there is no flush.
- `scan_en`=1 with `in_valid`=0 leaves the counter unchanged.

## Structure
- Package `mux_tree_pkg`:
  - constants `RADIX=4`, `SEL_BITS_PER_LEVEL=2`;
  - function `n_inputs(levels)` returning 4**levels;
  - function `sel_width(levels)`.
- Sub-module `mux4_stage`, parameter `WIDTH`:
  - inputs: four WIDTH-bit words, 2-bit select, enable;
  - registered output with async active-high reset to 0.
- Top level:
  - a generate loop instantiates 4**(LEVELS-1-k) `mux4_stage` at level k;
  - a single shift pipeline carries {valid, carried select, wrap flag}.

## Test plan
- Fixed select (defaults): word i = i mod 2; `select`=5 for one cycle with `in_valid` → exactly one `out_valid` pulse, two cycles after launch, with `out`=1 and `out_sel`=5.
- Streaming, WIDTH=8, LEVELS=2: word i = 8'hA0+i; `select`=0,1,…,15 on 16 consecutive `in_valid` cycles → 16 consecutive valid outputs 8'hA0…8'hAF in order, with matching `out_sel`.
- Scan mode: `scan_en`=1 and `in_valid`=1 for 18 cycles → `out_sel` sequence 0…15,0,1; `scan_wrap`=1 only on the output with `out_sel`=15.
- Scan pause/resume: scan 5 words, drop `scan_en` for 3 cycles using `select`=9, then resume → `out_sel` sequence 0–4, 9,9,9, then 5,6…
- Reset mid-stream: assert `rst` while 2 words are in flight → `out_valid`, `out_sel` and `scan_wrap` go 0 asynchronously; after release, the scan restarts at `out_sel`=0.
- LEVELS=1 and LEVELS=3 (WIDTH=4): random select/data/bubbles checked against the reference model `out = data[sel*WIDTH +: WIDTH]` delayed by LEVELS cycles.
